// File: rtl/regfile_pkg.sv
// Shared constants for the 16-bit processor register file.
// Widths, register count, write-mode encodings and the fixed R15 address.
// No logic; imported by reg_file and its testbench.
package regfile_pkg;

  localparam int REG_W    = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_ONE  = 2'b01;
  localparam logic [1:0] WR_TWO  = 2'b10;
  localparam logic [1:0] WR_R15  = 2'b11;

  localparam logic [ADDR_W-1:0] R15_ADDR = 4'hF;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 16 x 16-bit, two read ports, R15 port, full dump.
// Latency: reads combinational (0), writes visible after 1 rising edge.
// Backpressure: none; writes always accepted, blocked only while reset is high.
module reg_file
  import regfile_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  rWrite,
  input  logic [ADDR_W-1:0]           op1,
  input  logic [ADDR_W-1:0]           op2,
  input  logic [ADDR_W-1:0]           wop1,
  input  logic [ADDR_W-1:0]           wop2,
  input  logic [REG_W-1:0]            wdata1,
  input  logic [REG_W-1:0]            wdata2,
  input  logic [REG_W-1:0]            r15data,
  output logic [REG_W-1:0]            data1,
  output logic [REG_W-1:0]            data2,
  output logic [REG_W-1:0]            r15dataout,
  output logic [0:NUM_REGS*REG_W-1]   regout
);

  logic [REG_W-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] we;
  logic [REG_W-1:0]    wd   [NUM_REGS];

  // Per-register write-enable/data decode; later assignments win, which gives
  // wdata2 priority on a port-1/port-2 collision and r15data priority on R15.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      we[i] = 1'b0;
      wd[i] = '0;
    end
    if (rWrite != WR_NONE) begin
      we[wop1] = 1'b1;
      wd[wop1] = wdata1;
    end
    if (rWrite == WR_TWO) begin
      we[wop2] = 1'b1;
      wd[wop2] = wdata2;
    end
    if (rWrite == WR_R15) begin
      we[R15_ADDR] = 1'b1;
      wd[R15_ADDR] = r15data;
    end
  end

  // Register array: async clear, enabled load on the rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we[i]) regs[i] <= wd[i];
      end
    end
  end

  assign data1      = regs[op1];
  assign data2      = regs[op2];
  assign r15dataout = regs[R15_ADDR];

  // Debug dump: R0 at [0:15] ... R15 at [240:255], MSB at the lower index.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dump
    assign regout[g*REG_W +: REG_W] = regs[g];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus random writes
// compared against a plain array model of the sixteen registers.
module tb_reg_file;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rWrite;
  logic [3:0]  op1, op2, wop1, wop2;
  logic [15:0] wdata1, wdata2, r15data;
  logic [15:0] data1, data2, r15dataout;
  logic [0:255] regout;

  logic [15:0] model [16];
  int total = 0;
  int bad   = 0;

  reg_file dut (
    .clk(clk), .reset(reset), .rWrite(rWrite),
    .op1(op1), .op2(op2), .wop1(wop1), .wop2(wop2),
    .wdata1(wdata1), .wdata2(wdata2), .r15data(r15data),
    .data1(data1), .data2(data2), .r15dataout(r15dataout),
    .regout(regout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one write at the next rising edge and update the model.
  task automatic do_write(input logic [1:0] m, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d15);
    @(negedge clk);
    rWrite = m; wop1 = a1; wop2 = a2; wdata1 = d1; wdata2 = d2; r15data = d15;
    @(posedge clk);
    #1;
    rWrite = WR_NONE;
    if (m != WR_NONE) model[a1] = d1;
    if (m == WR_TWO)  model[a2] = d2;
    if (m == WR_R15)  model[15] = d15;
  endtask

  // Compare every read path against the model.
  task automatic check_all(input string tag);
    logic [15:0] s;
    for (int i = 0; i < 16; i++) begin
      op1 = 4'(i);
      op2 = 4'(15 - i);
      #1;
      chk({tag, ".data1"}, data1, model[i]);
      chk({tag, ".data2"}, data2, model[15 - i]);
      s = regout[16*i +: 16];
      chk({tag, ".regout"}, s, model[i]);
    end
    chk({tag, ".r15"}, r15dataout, model[15]);
  endtask

  initial begin
    logic [15:0] old4, s;
    reset = 1'b1; rWrite = WR_NONE;
    op1 = '0; op2 = '0; wop1 = '0; wop2 = '0;
    wdata1 = '0; wdata2 = '0; r15data = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;

    // Single write; R9 and R15 must not move.
    do_write(WR_ONE, 4'h8, 4'h9, 16'hAFAF, 16'hBCBC, 16'h000D);
    op1 = 4'h8; #1;
    chk("m01.r8", data1, 16'hAFAF);
    check_all("m01");

    // Two-register write, then same-address collision.
    do_write(WR_TWO, 4'hA, 4'hB, 16'hEEEE, 16'h0110, 16'h7777);
    check_all("m10");
    do_write(WR_TWO, 4'h3, 4'h3, 16'h1234, 16'h5678, 16'h7777);
    op1 = 4'h3; #1;
    chk("m10.coll", data1, 16'h5678);

    // Write plus R15, then R15 collision.
    do_write(WR_R15, 4'hC, 4'hD, 16'hAAAA, 16'h9999, 16'h5555);
    chk("m11.r15", r15dataout, 16'h5555);
    check_all("m11");
    do_write(WR_R15, 4'hF, 4'h0, 16'hAAAA, 16'h9999, 16'h4321);
    chk("m11.coll", r15dataout, 16'h4321);

    // Read-during-write: old value before the edge, new after.
    old4 = model[4];
    @(negedge clk);
    op1 = 4'h4; wop1 = 4'h4; wdata1 = ~old4; rWrite = WR_ONE;
    #1;
    chk("rdw.before", data1, old4);
    @(posedge clk); #1;
    rWrite = WR_NONE;
    model[4] = ~old4;
    chk("rdw.after", data1, ~old4);

    // Distinct value in every register; check dump endpoints explicitly.
    for (int i = 0; i < 16; i++)
      do_write(WR_ONE, 4'(i), 4'h0, 16'h1000 + 16'(i) * 16'h0111, 16'h0, 16'h0);
    check_all("pack");
    s = regout[0:15];
    chk("pack.r0", s, 16'h1000);
    s = regout[240:255];
    chk("pack.r15", s, 16'h1000 + 16'd15 * 16'h0111);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      do_write(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom));
      if (n % 20 == 19) check_all("rnd");
    end
    check_all("rnd.end");

    // Asynchronous reset mid-cycle, writes blocked while held.
    @(negedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    #1;
    chk("arst.r15", r15dataout, 16'h0000);
    s = regout[0:15];
    chk("arst.r0", s, 16'h0000);
    rWrite = WR_R15; wop1 = 4'h2; wdata1 = 16'hBEEF; r15data = 16'hCAFE;
    @(posedge clk); #1;
    rWrite = WR_NONE;
    check_all("arst.hold");
    @(negedge clk);
    reset = 1'b0;
    do_write(WR_ONE, 4'h2, 4'h0, 16'hBEEF, 16'h0, 16'h0);
    check_all("arst.post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the 16-bit processor datapath: sixteen 16-bit general registers, two combinational read ports and a dedicated R15 read port. Writes are clocked and selected by a 2-bit write mode. Modes cover no write, one write, a two-register write (swap-style) and a write plus R15 update (multiply/divide high word). A flattened 256-bit dump of all registers is provided for debug and trace.

## Interface
- Parameters: none (widths fixed; constants live in the shared package).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: sole clock; all register updates occur on the rising edge.
- `reset` in 1: asynchronous, active-high; clears every register.
- `rWrite` in 2: write mode (see Operation).
- `op1` in 4: read address, port 1.
- `op2` in 4: read address, port 2.
- `wop1` in 4: write address, port 1.
- `wop2` in 4: write address, port 2.
- `wdata1` in 16: write data, port 1.
- `wdata2` in 16: write data, port 2.
- `r15data` in 16: write data for R15 in mode 11.
- `data1` out 16: contents of register `op1`.
- `data2` out 16: contents of register `op2`.
- `r15dataout` out 16: contents of R15.
- `regout` out 256, declared [0:255]: register i occupies bits [16i : 16i+15], MSB at the lower index. R0 is bits [0:15] and R15 is bits [240:255].

## Operation
- Storage: 16 × 16-bit registers, R0–R15. R0 is an ordinary writable register, not hardwired to zero.
- Reads are combinational from current register state. `data1`, `data2`, `r15dataout` and `regout` change only when addresses change or after a clock edge/reset.
- Write modes, sampled at the rising edge of `clk`:
  - 00: no write.
  - 01: R[`wop1`] ← `wdata1`.
  - 10: R[`wop1`] ← `wdata1` and R[`wop2`] ← `wdata2`.
  - 11: R[`wop1`] ← `wdata1` and R15 ← `r15data`.
- `wop2`/`wdata2` are ignored in modes 00, 01 and 11. `r15data` is ignored in modes 00, 01 and 10.
- Collisions:
  - Mode 10 with `wop1` == `wop2`: `wdata2` wins.
  - Mode 11 with `wop1` == 15: `r15data` wins.
- Reset: all sixteen registers go to 0x0000. Every output then reads 0x0000.
- `rWrite` X/Z is not a supported input. Callers drive 00 when idle.

## Timing
- Read latency 0 (combinational address-to-data).
- Write latency 1 edge: the new value is visible on read outputs immediately after the rising edge that sampled it.
- Read-during-write to the same address in the same cycle returns the old value until the edge. No internal bypass.
- Reset asynchronous: registers clear immediately on `reset` rising, independent of `clk`. While `reset` is high, all writes are blocked.
- Deassertion of `reset` should be synchronized by the system. The first write takes effect on the first rising edge with `reset` low.

## Structure
- Shared package `regfile_pkg`:
  - `REG_W` = 16, `NUM_REGS` = 16, `ADDR_W` = 4.
  - Write-mode constants `WR_NONE` = 2'b00, `WR_ONE` = 2'b01, `WR_TWO` = 2'b10, `WR_R15` = 2'b11.
  - `R15_ADDR` = 4'hF.
- Single module `reg_file`: register array, two read muxes, write-enable decode per register, and a generate loop packing `regout`.
- No sub-module required. An optional per-register leaf `reg16` (async-clear, enable, 16-bit) is acceptable.

## Test plan
- Reset: assert `reset` mid-cycle → all `regout` 0x0000 immediately; `data1`/`data2`/`r15dataout` = 0x0000.
- Mode 01, `wop1`=8, `wdata1`=0xAFAF, `wdata2`=0xBCBC, `r15data`=0x000D → after edge R8=0xAFAF. R9 and R15 remain unchanged. Set `op1`=8 → `data1`=0xAFAF with no cycle delay.
- Mode 10, `wop1`=A, `wop2`=B, `wdata1`=0xEEEE, `wdata2`=0x0110 → RA=0xEEEE, RB=0x0110, R15 unchanged. Repeat with `wop1`=`wop2`=3 → R3=`wdata2`.
- Mode 11, `wop1`=C, `wdata1`=0xAAAA, `r15data`=0x5555 → RC=0xAAAA, R15=0x5555, `r15dataout`=0x5555, RD unchanged. Repeat with `wop1`=F → R15=`r15data`.
- Read-during-write: `op1`=`wop1`=4 in mode 01 → `data1` shows the old value before the edge and the new value after it.
- `regout` packing: write a distinct value to every register → each 16-bit slice matches its register; R0 is at [0:15] and R15 at [240:255].
